// File: rtl/ldl_ring_align.sv
// Iterative inverse of the ring shifter: finds the (dir, step) rotation that
// maps source word x onto target word y, testing one rotation per clock.
module ldl_ring_align #(
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           x,
    input  logic [WIDTH-1:0]           y,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       found,
    output logic                       dir,
    output logic [$clog2(WIDTH)-1:0]   step,
    output logic                       busy
);

    localparam int SW = $clog2(WIDTH);
    localparam logic [SW-1:0] CNT_LAST = SW'(WIDTH - 1);
    localparam logic [SW:0]   HALF     = (SW + 1)'(WIDTH / 2);
    localparam logic [SW:0]   WID      = (SW + 1)'(WIDTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [WIDTH-1:0]  work;
    logic [WIDTH-1:0]  target;
    logic [SW-1:0]     cnt;

    logic              hit;
    logic              last;
    logic              enc_dir;
    logic [SW-1:0]     enc_step;
    logic [SW:0]       k_ext;
    logic [SW:0]       k_left;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (clear) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (in_valid) state_next = SEARCH;
                SEARCH:  if (hit || last) state_next = DONE;
                DONE:    if (out_ready) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Right-rotation count k maps to the shorter direction; a tie at WIDTH/2 stays right.
    always_comb begin
        in_ready = rst_n && (state == IDLE);
        busy     = (state == SEARCH) || (state == DONE);
        hit      = (work == target);
        last     = (cnt == CNT_LAST);
        k_ext    = {1'b0, cnt};
        k_left   = WID - k_ext;
        enc_dir  = 1'b0;
        enc_step = cnt;
        if (k_ext > HALF) begin
            enc_dir  = 1'b1;
            enc_step = k_left[SW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            work      <= '0;
            target    <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            found     <= 1'b0;
            dir       <= 1'b0;
            step      <= '0;
        end else if (clear) begin
            out_valid <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        work   <= x;
                        target <= y;
                        cnt    <= '0;
                    end
                end
                SEARCH: begin
                    if (hit) begin
                        out_valid <= 1'b1;
                        found     <= 1'b1;
                        dir       <= enc_dir;
                        step      <= enc_step;
                    end else if (last) begin
                        out_valid <= 1'b1;
                        found     <= 1'b0;
                        dir       <= 1'b0;
                        step      <= '0;
                    end else begin
                        work <= {work[0], work[WIDTH-1:1]};
                        cnt  <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: begin
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ldl_ring_align.sv
// Self-checking bench for ldl_ring_align (WIDTH=8): vector table, scoreboard queue,
// handshake/clear/reset corner sequences and random rotations through a shifter model.
module tb_ldl_ring_align;

    localparam int WIDTH = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clear;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] x;
    logic [7:0] y;
    logic       out_valid;
    logic       out_ready;
    logic       found;
    logic       dir;
    logic [2:0] step;
    logic       busy;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [7:0] x;
        logic [7:0] y;
        logic       found;
        logic       dir;
        logic [2:0] step;
        int         lat;
    } vec_t;

    typedef struct {
        logic [7:0] x;
        logic [7:0] y;
        bit         known;
        logic       found;
        logic       dir;
        logic [2:0] step;
        int         lat;
    } exp_t;

    vec_t vecs[12];
    exp_t sb[$];

    always #5 clk = ~clk;

    ldl_ring_align #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .found     (found),
        .dir       (dir),
        .step      (step),
        .busy      (busy)
    );

    // Ring shifter reference: dir 0 rotates right, dir 1 rotates left.
    function automatic logic [7:0] ringShift(input logic [7:0] v, input logic d, input int s);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = d ? v[(i - s + 8) % 8] : v[(i + s) % 8];
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] ax, input logic [7:0] ay, input bit known,
                                 input logic ef, input logic ed, input logic [2:0] es, input int lat);
        exp_t e;
        int   n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        checkOutput("in_ready before accept", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        x        = ax;
        y        = ay;
        tick();
        in_valid = 1'b0;
        x        = 8'($urandom);
        y        = 8'($urandom);
        e.x = ax; e.y = ay; e.known = known;
        e.found = ef; e.dir = ed; e.step = es; e.lat = lat;
        sb.push_back(e);
    endtask

    task automatic waitResult(input string name);
        exp_t e;
        int   n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        checkOutput({name, " out_valid"}, {31'd0, out_valid}, 32'd1);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s scoreboard: got result expected none", name);
        end else begin
            e = sb.pop_front();
            if (e.lat >= 0) checkOutput({name, " latency"}, n, e.lat);
            if (e.known) begin
                checkOutput({name, " found"}, {31'd0, found}, {31'd0, e.found});
                checkOutput({name, " dir"},   {31'd0, dir},   {31'd0, e.dir});
                checkOutput({name, " step"},  {29'd0, step},  {29'd0, e.step});
            end else begin
                checkOutput({name, " found"}, {31'd0, found}, 32'd1);
                checkOutput({name, " reproduce"}, {24'd0, ringShift(e.x, dir, int'(step))}, {24'd0, e.y});
                checkOutput({name, " canonical"}, {31'd0, (dir && (step == 3'd0 || step >= 3'd4))}, 32'd0);
            end
        end
    endtask

    task automatic consume(input string name);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput({name, " out_valid drop"}, {31'd0, out_valid}, 32'd0);
        checkOutput({name, " in_ready after"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0]  = '{8'h01, 8'h80, 1'b1, 1'b0, 3'd1, 2};
        vecs[1]  = '{8'h01, 8'h02, 1'b1, 1'b1, 3'd1, 8};
        vecs[2]  = '{8'h00, 8'h00, 1'b1, 1'b0, 3'd0, 1};
        vecs[3]  = '{8'hAA, 8'h55, 1'b1, 1'b0, 3'd1, 2};
        vecs[4]  = '{8'h01, 8'h03, 1'b0, 1'b0, 3'd0, 8};
        vecs[5]  = '{8'h01, 8'h10, 1'b1, 1'b0, 3'd4, 5};
        vecs[6]  = '{8'h01, 8'h08, 1'b1, 1'b1, 3'd3, 6};
        vecs[7]  = '{8'h81, 8'hC0, 1'b1, 1'b0, 3'd1, 2};
        vecs[8]  = '{8'hFF, 8'hFF, 1'b1, 1'b0, 3'd0, 1};
        vecs[9]  = '{8'h11, 8'h11, 1'b1, 1'b0, 3'd0, 1};
        vecs[10] = '{8'h11, 8'h88, 1'b1, 1'b0, 3'd1, 2};
        vecs[11] = '{8'hF0, 8'h0F, 1'b1, 1'b0, 3'd4, 5};

        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        x = 8'h00; y = 8'h00;
        tick();
        tick();
        checkOutput("reset in_ready",  {31'd0, in_ready},  32'd0);
        checkOutput("reset out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("reset found",     {31'd0, found},     32'd0);
        checkOutput("reset dir",       {31'd0, dir},       32'd0);
        checkOutput("reset step",      {29'd0, step},      32'd0);
        checkOutput("reset busy",      {31'd0, busy},      32'd0);
        rst_n = 1'b1;
        #1;
        checkOutput("in_ready after reset", {31'd0, in_ready}, 32'd1);

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].x, vecs[i].y, 1'b1, vecs[i].found, vecs[i].dir, vecs[i].step, vecs[i].lat);
            checkOutput($sformatf("vec%0d busy", i), {31'd0, busy}, 32'd1);
            waitResult($sformatf("vec%0d", i));
            consume($sformatf("vec%0d", i));
        end

        // Stall in DONE with a competing request, then a back-to-back job.
        $display("[TB] stall sequence");
        applyStimulus(8'h01, 8'h80, 1'b1, 1'b1, 1'b0, 3'd1, 2);
        waitResult("stall");
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1; x = 8'h01; y = 8'h02;
            tick();
            checkOutput($sformatf("stall%0d out_valid", c), {31'd0, out_valid}, 32'd1);
            checkOutput($sformatf("stall%0d in_ready", c),  {31'd0, in_ready},  32'd0);
            checkOutput($sformatf("stall%0d result", c),    {27'd0, found, dir, step}, {27'd0, 1'b1, 1'b0, 3'd1});
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        checkOutput("stall release out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("stall no accept busy",    {31'd0, busy},      32'd0);
        applyStimulus(8'h01, 8'h02, 1'b1, 1'b1, 1'b1, 3'd1, 8);
        waitResult("backtoback");
        consume("backtoback");

        // Abort with clear while cnt==3.
        $display("[TB] clear sequence");
        applyStimulus(8'h01, 8'h02, 1'b1, 1'b1, 1'b1, 3'd1, 8);
        repeat (3) tick();
        clear = 1'b1; in_valid = 1'b1; x = 8'h00; y = 8'h00;
        tick();
        sb.delete(sb.size() - 1);
        checkOutput("clear out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("clear busy",      {31'd0, busy},      32'd0);
        tick();
        checkOutput("clear blocks accept", {31'd0, busy}, 32'd0);
        clear = 1'b0; in_valid = 1'b0;
        applyStimulus(8'h01, 8'h08, 1'b1, 1'b1, 1'b1, 3'd3, 6);
        waitResult("after clear");
        consume("after clear");

        // Reset while cnt==3.
        $display("[TB] reset sequence");
        applyStimulus(8'h01, 8'h02, 1'b1, 1'b1, 1'b1, 3'd1, 8);
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        sb.delete(sb.size() - 1);
        checkOutput("midreset in_ready",  {31'd0, in_ready},  32'd0);
        checkOutput("midreset out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("midreset result",    {27'd0, found, dir, step}, 32'd0);
        checkOutput("midreset busy",      {31'd0, busy},      32'd0);
        rst_n = 1'b1;
        applyStimulus(8'h01, 8'h10, 1'b1, 1'b1, 1'b0, 3'd4, 5);
        waitResult("after reset");
        consume("after reset");

        // Random words rotated through the shifter model.
        $display("[TB] random sequence");
        for (int r = 0; r < 10; r++) begin
            logic [7:0] rx;
            logic       rd;
            int         rs;
            rx = 8'($urandom);
            rd = 1'($urandom_range(0, 1));
            rs = int'($urandom_range(0, 7));
            applyStimulus(rx, ringShift(rx, rd, rs), 1'b0, 1'b1, 1'b0, 3'd0, -1);
            waitResult($sformatf("rand%0d", r));
            consume($sformatf("rand%0d", r));
        end

        checkOutput("scoreboard empty", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
